ps2_scancode_decoder: RTL and testbench
=======================================

# ps2_scancode_decoder

Converts the raw PS/2 byte stream from `PS2_Controller` (Set 2 scan codes) into decoded key events. Handles the `E0`/`F0` prefixes and the `E1` Pause sequence, flags typematic repeats, and tracks which keys are held. Events are buffered in a parametrised first-word-fall-through FIFO with a valid/ready handshake. A parametrised raw-byte history replaces the single last-byte register for hex display. The block sits between `PS2_Controller` and the game logic.

## Interface

Parameters:
- `FIFO_DEPTH`, default 8: event FIFO entries. Power of two, minimum 2.
- `HISTORY`, default 2: number of most recent raw bytes kept for display. Minimum 1.

Ports:
- `CLOCK_50`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `received_data`, in, 8: byte from `PS2_Controller`.
- `received_data_en`, in, 1: one-cycle strobe marking `received_data` as valid.
- `evt_valid`, out, 1: FIFO not empty.
- `evt_ready`, in, 1: consumer pops the head entry when `evt_valid` and `evt_ready` are both high.
- `evt_data`, out, 11: head entry `{repeat, ext, brk, code[7:0]}`.
- `evt_count`, out, clog2(FIFO_DEPTH)+1: current number of FIFO entries.
- `overflow`, out, 1: sticky; set when an event is dropped.
- `key_down`, out, 512: held-key map, indexed by `{ext, code}`.
- `last_status`, out, 8: most recent keyboard status byte.
- `byte_history`, out, 8*HISTORY: raw bytes, newest in `[7:0]`.

## Operation

Reset values: all outputs and internal registers are 0, the FSM is in IDLE and the FIFO is empty.

History: every strobe shifts `received_data` into `byte_history[7:0]` and moves the older bytes up. This happens for every byte, including status bytes and bytes skipped by the Pause sequence.

Status bytes `FA`, `AA`, `EE`, `FE`, `FC`, `00`, `FF`:
- Recognised only when the FSM is in IDLE.
- Latched into `last_status`.
- Produce no event and do not change the FSM state.

Decoder FSM. A transition is taken only on a strobe.
- IDLE:
  - `E0` → EXT.
  - `F0` → BRK.
  - `E1` → PAUSE, and the skip counter is loaded with 7.
  - Any other non-status byte: emit a make event with ext=0, then stay in IDLE.
- EXT:
  - `F0` → EXTBRK.
  - `E0` stays in EXT (it is ignored).
  - Any other byte: emit a make event with ext=1, then → IDLE.
- BRK: any byte emits a break event with ext=0, then → IDLE.
- EXTBRK: any byte emits a break event with ext=1, then → IDLE.
- PAUSE: each strobe decrements the skip counter. When it reaches 0:
  - emit the event `{0,1,0,8'h77}`;
  - → IDLE;
  - `key_down` is not changed for this event.

Event fields and key map:
- A make event sets `repeat = key_down[{ext,code}]` (the value before the update), then sets that bit.
- A break event always has repeat=0 and clears the bit.
- The `key_down` update happens even when the event is dropped because the FIFO is full.

FIFO:
- A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
- Otherwise the event is dropped and `overflow` is set. `overflow` clears only on `reset`.
- Push and pop in the same cycle: `evt_count` is unchanged.
- Pop when empty is ignored.
- Pointers wrap modulo FIFO_DEPTH.

## Timing

- Decode latency: the strobe in cycle N updates the FSM, `key_down`, `last_status` and `byte_history` at the edge ending cycle N.
- `evt_valid` rises in cycle N+1 when the FIFO was empty.
- `evt_data` is registered and fall-through: the head is valid while `evt_valid` is high. The next entry appears in the cycle after a pop.
- One strobe produces at most one push, so throughput is one event per cycle.
- `reset` asserted mid-sequence (for example in EXT, or part-way through PAUSE) returns to IDLE in the next cycle. Any strobe in a reset cycle is ignored.
- `evt_ready` may be held high permanently. `evt_data` is don't-care while `evt_valid` is low.

## Test plan

- Make, typematic repeat, then break: bytes `1C`, `1C`, `F0 1C` → events `0x01C`, `0x41C`, `0x11C`; `key_down[0x01C]` reads 1 after the first byte and 0 at the end.
- Extended make/break: bytes `E0 75`, `E0 F0 75` → events `0x275`, `0x375`; `key_down[0x175]` is set, then cleared.
- Pause plus status: bytes `E1 14 77 E1 F0 14 F0 77` → exactly one event `0x277`. Then byte `FA` → `last_status=0xFA` and no event. With `HISTORY=2`, `byte_history` reads `0x77FA` (newest byte `FA` in `[7:0]`).
- Overflow: `FIFO_DEPTH=4`, `evt_ready=0`, six distinct makes → `evt_count=4`, `overflow=1`, and the FIFO holds the first four codes in order. Then hold `evt_ready=1` → the four codes drain in order and `evt_valid` falls.
- Full-FIFO simultaneous push/pop: `FIFO_DEPTH=4`, FIFO full, `evt_ready=1` in the same cycle as a new make → accepted, `evt_count` stays 4, `overflow` stays 0.
- Reset mid-sequence: bytes `E0 F0`, then `reset` for 1 cycle, then `1C` → event `0x01C` with ext=0 and brk=0; all outputs read 0 during the cycle after reset.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set 2 byte stream to key events: prefix/Pause decoding, held-key map,
// raw byte history and a first-word-fall-through event FIFO.
//
//  state    | meaning
//  ---------+----------------------------------------------------
//  S_IDLE   | waiting for a code, prefix or status byte
//  S_EXT    | E0 seen, next non-prefix byte is an extended make
//  S_BRK    | F0 seen, next byte is a break code
//  S_EXTBRK | E0 F0 seen, next byte is an extended break code
//  S_PAUSE  | skipping the remainder of the E1 Pause sequence
module ps2_scancode_decoder #(
   parameter int FIFO_DEPTH = 8,
   parameter int HISTORY    = 2
) (
   input  logic                          CLOCK_50,
   input  logic                          reset,
   input  logic [7:0]                    received_data,
   input  logic                          received_data_en,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [10:0]                   evt_data,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count,
   output logic                          overflow,
   output logic [511:0]                  key_down,
   output logic [7:0]                    last_status,
   output logic [8*HISTORY-1:0]          byte_history
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_PAUSE} state_t;

   state_t      state, state_nxt;
   logic [2:0]  skip_cnt, skip_nxt;
   logic        emit, emit_ext, emit_brk, emit_pause, status_hit, is_status;
   logic [8:0]  key_idx;
   logic [10:0] evt_new;
   logic        push, pop, full;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [10:0] mem [FIFO_DEPTH];

   assign is_status = received_data inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};

   always_comb begin
      state_nxt  = state;
      skip_nxt   = skip_cnt;
      emit       = 1'b0;
      emit_ext   = 1'b0;
      emit_brk   = 1'b0;
      emit_pause = 1'b0;
      status_hit = 1'b0;
      if (received_data_en) begin
         case (state)
            S_IDLE: begin
               if (is_status)                  status_hit = 1'b1;
               else if (received_data == 8'hE0) state_nxt = S_EXT;
               else if (received_data == 8'hF0) state_nxt = S_BRK;
               else if (received_data == 8'hE1) begin
                  state_nxt = S_PAUSE;
                  skip_nxt  = 3'd7;
               end else                         emit = 1'b1;
            end
            S_EXT: begin
               if (received_data == 8'hF0)      state_nxt = S_EXTBRK;
               else if (received_data != 8'hE0) begin
                  emit      = 1'b1;
                  emit_ext  = 1'b1;
                  state_nxt = S_IDLE;
               end
            end
            S_BRK: begin
               emit      = 1'b1;
               emit_brk  = 1'b1;
               state_nxt = S_IDLE;
            end
            S_EXTBRK: begin
               emit      = 1'b1;
               emit_ext  = 1'b1;
               emit_brk  = 1'b1;
               state_nxt = S_IDLE;
            end
            S_PAUSE: begin
               // terminal count: this strobe is the last byte of the Pause sequence
               if (skip_cnt == 3'd1) begin
                  emit       = 1'b1;
                  emit_pause = 1'b1;
                  skip_nxt   = 3'd0;
                  state_nxt  = S_IDLE;
               end else begin
                  skip_nxt = skip_cnt - 3'd1;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   assign key_idx = {emit_ext, received_data};
   assign evt_new = emit_pause ? {1'b0, 1'b1, 1'b0, 8'h77}
                               : {~emit_brk & key_down[key_idx], emit_ext, emit_brk, received_data};

   assign evt_valid = (evt_count != '0);
   assign full      = (evt_count == DEPTH_C);
   assign pop       = evt_valid & evt_ready;
   assign push      = emit & (~full | pop);
   assign evt_data  = mem[rd_ptr];

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state        <= S_IDLE;
         skip_cnt     <= '0;
         key_down     <= '0;
         last_status  <= '0;
         byte_history <= '0;
         overflow     <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         evt_count    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         state    <= state_nxt;
         skip_cnt <= skip_nxt;
         if (received_data_en) begin
            for (int i = HISTORY-1; i > 0; i--)
               byte_history[i*8 +: 8] <= byte_history[(i-1)*8 +: 8];
            byte_history[7:0] <= received_data;
         end
         if (status_hit) last_status <= received_data;
         // key map follows the keyboard even when the FIFO drops the event
         if (emit && !emit_pause) key_down[key_idx] <= ~emit_brk;
         if (push) begin
            mem[wr_ptr] <= evt_new;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (emit && !push) overflow <= 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   evt_count <= evt_count + 1'b1;
            2'b01:   evt_count <= evt_count - 1'b1;
            default: evt_count <= evt_count;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: table vectors from the key-event examples,
// hand-written corner sequences, and a randomized run against a queue model.
module tb_ps2_scancode_decoder;

   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   received_data;
   logic         received_data_en;
   logic         evt_valid;
   logic         evt_ready;
   logic [10:0]  evt_data;
   logic [2:0]   evt_count;
   logic         overflow;
   logic [511:0] key_down;
   logic [7:0]   last_status;
   logic [15:0]  byte_history;

   ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .HISTORY(2)) dut (
      .CLOCK_50(clk), .reset(reset), .received_data(received_data),
      .received_data_en(received_data_en), .evt_valid(evt_valid),
      .evt_ready(evt_ready), .evt_data(evt_data), .evt_count(evt_count),
      .overflow(overflow), .key_down(key_down), .last_status(last_status),
      .byte_history(byte_history));

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // behavioural model: pending-prefix flags, a skip countdown, and a bounded queue
   logic [10:0]  q[$];
   logic [511:0] m_keys;
   logic         m_ovf, m_ext_pend, m_brk_pend;
   logic [7:0]   m_status;
   logic [15:0]  m_hist;
   int           m_pause_left;

   function automatic bit status_byte(input logic [7:0] b);
      return b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE ||
             b == 8'hFC || b == 8'h00 || b == 8'hFF;
   endfunction

   task automatic model_reset();
      q.delete();
      m_keys = '0; m_ovf = 0; m_ext_pend = 0; m_brk_pend = 0;
      m_status = '0; m_hist = '0; m_pause_left = 0;
   endtask

   task automatic model_step(input logic en, input logic [7:0] b, input logic rdy);
      bit          do_pop, have;
      logic [10:0] ev;
      logic [8:0]  idx;
      do_pop = rdy && (q.size() > 0);
      have = 0;
      ev = '0;
      if (en) begin
         m_hist = {m_hist[7:0], b};
         if (m_pause_left > 0) begin
            m_pause_left--;
            if (m_pause_left == 0) begin ev = 11'h277; have = 1; end
         end else if (!m_ext_pend && !m_brk_pend && status_byte(b)) m_status = b;
         else if (b == 8'hE0 && !m_brk_pend) m_ext_pend = 1;
         else if (b == 8'hF0 && !m_brk_pend) m_brk_pend = 1;
         else if (b == 8'hE1 && !m_ext_pend && !m_brk_pend) m_pause_left = 7;
         else begin
            idx = {m_ext_pend, b};
            if (m_brk_pend) begin
               ev = {1'b0, m_ext_pend, 1'b1, b};
               m_keys[idx] = 1'b0;
            end else begin
               ev = {m_keys[idx], m_ext_pend, 1'b0, b};
               m_keys[idx] = 1'b1;
            end
            have = 1;
            m_ext_pend = 0;
            m_brk_pend = 0;
         end
      end
      if (do_pop) void'(q.pop_front());
      if (have) begin
         if (q.size() < DEPTH) q.push_back(ev);
         else m_ovf = 1;
      end
   endtask

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, evt_valid, q.size() != 0);
      chk({tag, ".count"}, evt_count, q.size());
      if (q.size() != 0) chk({tag, ".data"}, evt_data, q[0]);
      chk({tag, ".overflow"}, overflow, m_ovf);
      chk({tag, ".key_down"}, key_down, m_keys);
      chk({tag, ".last_status"}, last_status, m_status);
      chk({tag, ".history"}, byte_history, m_hist);
   endtask

   // called at a negedge; returns at the next negedge after the DUT edge
   task automatic cycle(input logic en, input logic [7:0] b, input logic rdy);
      received_data_en = en;
      received_data    = b;
      evt_ready        = rdy;
      model_step(en, b, rdy);
      @(negedge clk);
      received_data_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      received_data_en = 1'b1;
      received_data = 8'h1C;
      evt_ready = 1'b1;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      received_data_en = 1'b0;
      evt_ready = 1'b0;
   endtask

   typedef struct {
      int          nb;
      logic [7:0]  b [8];
      int          ne;
      logic [10:0] e [3];
   } vec_t;

   vec_t vecs [3];
   logic [7:0] codes [6];

   initial begin
      vecs[0].nb = 4; vecs[0].b = '{8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[0].ne = 3; vecs[0].e = '{11'h01C, 11'h41C, 11'h11C};
      vecs[1].nb = 5; vecs[1].b = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h00, 8'h00, 8'h00};
      vecs[1].ne = 2; vecs[1].e = '{11'h275, 11'h375, 11'h000};
      vecs[2].nb = 8; vecs[2].b = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      vecs[2].ne = 1; vecs[2].e = '{11'h277, 11'h000, 11'h000};
      codes = '{8'h15, 8'h16, 8'h1D, 8'h24, 8'h2D, 8'h2C};

      reset = 1'b1; received_data = '0; received_data_en = 1'b0; evt_ready = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_all("reset");

      foreach (vecs[v]) begin
         for (int i = 0; i < vecs[v].nb; i++) begin
            cycle(1'b1, vecs[v].b[i], 1'b0);
            if (v == 0 && i == 0) chk("make.key_1c", key_down[9'h01C], 1'b1);
            if (v == 1 && i == 1) chk("ext.key_175", key_down[9'h175], 1'b1);
         end
         chk($sformatf("vec%0d.count", v), evt_count, vecs[v].ne);
         check_all($sformatf("vec%0d", v));
         for (int k = 0; k < vecs[v].ne; k++) begin
            chk($sformatf("vec%0d.valid%0d", v, k), evt_valid, 1'b1);
            chk($sformatf("vec%0d.evt%0d", v, k), evt_data, vecs[v].e[k]);
            cycle(1'b0, 8'h00, 1'b1);
         end
         chk($sformatf("vec%0d.drained", v), evt_valid, 1'b0);
      end
      chk("brk.key_1c", key_down[9'h01C], 1'b0);
      chk("ext.key_175_clr", key_down[9'h175], 1'b0);

      cycle(1'b1, 8'hFA, 1'b0);
      chk("status.last", last_status, 8'hFA);
      chk("status.no_evt", evt_count, 0);
      chk("status.history", byte_history, 16'h77FA);

      // overflow: six makes into a four-entry FIFO with no consumer
      foreach (codes[i]) cycle(1'b1, codes[i], 1'b0);
      chk("ovf.count", evt_count, 4);
      chk("ovf.flag", overflow, 1'b1);
      check_all("ovf");
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("ovf.drain%0d", k), evt_data, {3'b000, codes[k]});
         cycle(1'b0, 8'h00, 1'b1);
      end
      chk("ovf.empty", evt_valid, 1'b0);

      // full FIFO with a push and a pop in the same cycle
      do_reset();
      cycle(1'b1, 8'h21, 1'b0);
      cycle(1'b1, 8'h22, 1'b0);
      cycle(1'b1, 8'h23, 1'b0);
      cycle(1'b1, 8'h26, 1'b0);
      chk("full.count", evt_count, 4);
      cycle(1'b1, 8'h2A, 1'b1);
      chk("pushpop.count", evt_count, 4);
      chk("pushpop.overflow", overflow, 1'b0);
      chk("pushpop.head", evt_data, 11'h022);
      check_all("pushpop");

      // reset part-way through an extended break
      do_reset();
      cycle(1'b1, 8'hE0, 1'b0);
      cycle(1'b1, 8'hF0, 1'b0);
      do_reset();
      chk("rst.valid", evt_valid, 1'b0);
      chk("rst.count", evt_count, 0);
      chk("rst.data", evt_data, 0);
      chk("rst.overflow", overflow, 1'b0);
      chk("rst.key_down", key_down, 0);
      chk("rst.status", last_status, 0);
      chk("rst.history", byte_history, 0);
      cycle(1'b1, 8'h1C, 1'b0);
      chk("rst.evt_valid", evt_valid, 1'b1);
      chk("rst.evt", evt_data, 11'h01C);

      // randomized traffic against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         int r;
         logic [7:0] b;
         r = $urandom_range(0, 15);
         if (r < 2)       b = 8'hE0;
         else if (r < 4)  b = 8'hF0;
         else if (r == 4) b = 8'hE1;
         else if (r == 5) begin
            case ($urandom_range(0, 6))
               0: b = 8'hFA; 1: b = 8'hAA; 2: b = 8'hEE; 3: b = 8'hFE;
               4: b = 8'hFC; 5: b = 8'h00; default: b = 8'hFF;
            endcase
         end else b = 8'($urandom_range(16, 32));
         if ($urandom_range(0, 299) == 0) do_reset();
         else cycle(1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 2) != 0));
         check_all("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
